dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the load/store unit.
- Accepts word-aligned read/write requests carrying a 4-bit byte enable and pre-shifted store data.
- Performs each access on an internal byte-writable word array after a configurable number of wait states.
- Returns the full read word to the LSU, which handles byte/half extraction and sign extension.

Parameters:
- ADDR_WIDTH, 32: request address width (matches `DMEM_ADDR_WIDTH).
- DATA_WIDTH, 32: word width (matches `DMEM_DATA_WIDTH); must be 32.
- DEPTH_WORDS, 1024: array depth in words; power of two.
- WAIT_STATES, 1: extra cycles between accept and execution; 0..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- req_byte_en  in  4  store byte lanes; ignored for loads.
- req_wdata  in  DATA_WIDTH  store data, already lane-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read word; 0 for stores.
- rsp_err  out  1  access error, qualified by rsp_valid.

Behaviour:
- Reset values:
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - state=IDLE, wait counter=0.
  - Array contents are not reset.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready=1. On accept (req_valid & req_ready), capture we/addr/byte_en/wdata and load the counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else execute on the accept edge and go to RESP.
  - WAIT: req_ready=0. Counter decrements each cycle. On the edge leaving the cycle where the counter equals 1, execute and go to RESP.
  - RESP: rsp_valid=1 for exactly this cycle; req_ready=1. A new accept here follows the IDLE rules; otherwise go to IDLE.
- Execute, with word index = addr[log2(DEPTH_WORDS)+1:2]:
  - Store: write only the lanes whose byte_en bit is set. byte_en=0000 writes nothing but still responds, with rsp_rdata=0.
  - Load: rsp_rdata = full word at the index, registered.
- Latency: rsp_valid rises WAIT_STATES+1 cycles after the accept edge. Throughput is one request per WAIT_STATES+1 cycles; back-to-back at WAIT_STATES=0.
- No response backpressure: the LSU always consumes rsp_valid.
- Read-after-write: a load accepted in the store's RESP cycle returns the updated data.
- Reset asserted mid-WAIT: the pending operation is dropped, a store in WAIT is never committed, and no response is issued.
- req_* inputs are ignored while req_ready=0.

Optional Feature:
- Macro: DMEM_OOB_ERR_EN.
- Defined: an address with any set bit above index range is out of bounds. Such an access performs no write and returns rsp_rdata=0, rsp_err=1 in the RESP cycle, with normal latency.
- Undefined: upper address bits are ignored (accesses alias into the array); rsp_err is tied to 0.

Decomposition:
- defines.vh holds DMEM_ADDR_WIDTH, DMEM_DATA_WIDTH, DMEM_DEPTH_WORDS, DMEM_WAIT_STATES and the FSM state encodings (2-bit: IDLE=00, WAIT=01, RESP=10).
- One sub-module, dmem_bram: a single-port byte-enabled array with synchronous read (clk, we, byte_en, index, wdata, rdata).
- FSM and counter stay in dmem_ctrl.

Test Plan:
- WAIT_STATES=1, full-word store: store 0xDEADBEEF to 0x10 with byte_en=1111, then load 0x10 -> rsp_valid 2 cycles after each accept, and the load returns 0xDEADBEEF.
- Byte lane: with word 0x10=0xDEADBEEF, store byte_en=0100, wdata=0x00AA0000, then load -> 0xDEAABEEF.
- WAIT_STATES=0 back-to-back: store 0x11223344 to 0x20, then load 0x20 in the next cycle -> load response is 0x11223344; req_ready stays 1 throughout.
- WAIT_STATES=3 reset mid-op: store 0x55 to 0x30, drop rst_n one cycle after accept, then load 0x30 -> old value returned; no rsp_valid for the aborted store.
- Null store: store with byte_en=0000 to 0x10 -> rsp_valid=1, rsp_rdata=0, memory unchanged.
- DMEM_OOB_ERR_EN, DEPTH_WORDS=1024: store to 0x1000, then load 0x1000 -> rsp_err=1 on both, rdata=0, word 0 unchanged. Without the macro, word 0 is overwritten and rsp_err=0.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// ============================================================================
// Module      : dmem_ctrl_pkg
// Description : Shared defaults and FSM state encoding for the data-memory
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_ctrl_pkg;

  localparam int DMEM_ADDR_WIDTH  = 32;
  localparam int DMEM_DATA_WIDTH  = 32;
  localparam int DMEM_DEPTH_WORDS = 1024;
  localparam int DMEM_WAIT_STATES = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_bram.sv
// ============================================================================
// Module      : dmem_bram
// Description : Single-port byte-writable word array, synchronous read-first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_bram #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            byte_en,
  input  logic [IDX_W-1:0]      index,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  // One independent byte array per lane keeps each lane's write enable local.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] r_mem [DEPTH_WORDS];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (we && byte_en[i]) begin
        r_mem[index] <= wdata[8*i +: 8];
      end
      r_q <= r_mem[index];
    end

    assign rdata[8*i +: 8] = r_q;
  end

endmodule

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
// Module      : dmem_ctrl
// Description : LSU-facing data-memory controller with programmable wait
//               states. Optional macro DMEM_OOB_ERR_EN flags out-of-range
//               addresses instead of aliasing them into the array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DMEM_DATA_WIDTH,
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int WAIT_STATES = DMEM_WAIT_STATES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_byte_en,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int         c_idx_w = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_ws    = 4'(WAIT_STATES);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic                  r_rsp_load;

  logic                  w_accept;
  logic                  w_exec;
  logic                  w_op_we;
  logic [ADDR_WIDTH-1:0] w_op_addr;
  logic [3:0]            w_op_be;
  logic [DATA_WIDTH-1:0] w_op_wdata;
  logic                  w_oob;
  logic                  w_unused_addr;
  logic                  w_mem_we;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign req_ready = (r_state != ST_WAIT);
  assign w_accept  = req_valid & req_ready;

  // With no wait states the access happens on the accept edge straight from
  // the request bus; otherwise it runs from the captured copy.
  assign w_exec     = (WAIT_STATES == 0) ? w_accept
                                         : ((r_state == ST_WAIT) && (r_cnt == 4'd1));
  assign w_op_we    = (WAIT_STATES == 0) ? req_we      : r_we;
  assign w_op_addr  = (WAIT_STATES == 0) ? req_addr    : r_addr;
  assign w_op_be    = (WAIT_STATES == 0) ? req_byte_en : r_be;
  assign w_op_wdata = (WAIT_STATES == 0) ? req_wdata   : r_wdata;

`ifdef DMEM_OOB_ERR_EN
  assign w_oob         = |w_op_addr[ADDR_WIDTH-1:c_idx_w+2];
  assign w_unused_addr = ^w_op_addr[1:0];
`else
  assign w_oob         = 1'b0;
  assign w_unused_addr = ^{w_op_addr[ADDR_WIDTH-1:c_idx_w+2], w_op_addr[1:0]};
`endif

  // Reset gates the write so an operation in flight is never committed.
  assign w_mem_we = w_exec & w_op_we & ~w_oob & rst_n;

  dmem_bram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (c_idx_w)
  ) u_bram (
    .clk     (clk),
    .we      (w_mem_we),
    .byte_en (w_op_be),
    .index   (w_op_addr[c_idx_w+1:2]),
    .wdata   (w_op_wdata),
    .rdata   (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_load  <= 1'b0;
    end else begin
      r_rsp_valid <= w_exec;
      r_rsp_err   <= w_exec & w_oob;
      r_rsp_load  <= w_exec & ~w_op_we & ~w_oob;
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_be    <= req_byte_en;
            r_wdata <= req_wdata;
            r_cnt   <= c_ws;
            r_state <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= ST_RESP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = (r_rsp_valid && r_rsp_load) ? w_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Directed self-checking bench; three controllers with
//               WAIT_STATES of 1, 0 and 3. Honours DMEM_OOB_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_ctrl;

  function automatic int ws_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n       [3];
  logic        req_valid   [3];
  logic        req_ready   [3];
  logic        req_we      [3];
  logic [31:0] req_addr    [3];
  logic [3:0]  req_byte_en [3];
  logic [31:0] req_wdata   [3];
  logic        rsp_valid   [3];
  logic [31:0] rsp_rdata   [3];
  logic        rsp_err     [3];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_ctrl #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .DEPTH_WORDS (1024),
      .WAIT_STATES (ws_of(g))
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n[g]),
      .req_valid   (req_valid[g]),
      .req_ready   (req_ready[g]),
      .req_we      (req_we[g]),
      .req_addr    (req_addr[g]),
      .req_byte_en (req_byte_en[g]),
      .req_wdata   (req_wdata[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_rdata   (rsp_rdata[g]),
      .rsp_err     (rsp_err[g])
    );
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request and returns at the response cycle (+1 time unit).
  task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output logic rdy_after);
    int n;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    req_valid[d]   = 1'b1;
    req_we[d]      = we;
    req_addr[d]    = addr;
    req_byte_en[d] = be;
    req_wdata[d]   = wdata;
    @(posedge clk); #1;
    req_valid[d]   = 1'b0;
    req_wdata[d]   = 32'hFFFF_FFFF;
    rdy_after      = req_ready[d];
    lat            = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        rdy;
    int          lat;
    int          seen;

    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0;
      req_addr[i] = '0; req_byte_en[i] = '0; req_wdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check_val("rst_rsp_rdata", rsp_rdata[0], 32'd0);
    check_val("rst_rsp_err",   {31'd0, rsp_err[0]}, 32'd0);
    check_val("rst_req_ready", {31'd0, req_ready[0]}, 32'd1);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(posedge clk); #1;

    // WAIT_STATES=1: full-word store then load
    do_req(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, rd, er, lat, rdy);
    check_val("ws1_st_lat",   lat, 32'd2);
    check_val("ws1_st_ready", {31'd0, rdy}, 32'd0);
    check_val("ws1_st_rdata", rd, 32'd0);
    @(posedge clk); #1;
    check_val("ws1_pulse",    {31'd0, rsp_valid[0]}, 32'd0);
    do_req(0, 1'b0, 32'h10, 4'b0000, 32'h0, rd, er, lat, rdy);
    check_val("ws1_ld_lat",   lat, 32'd2);
    check_val("ws1_ld_data",  rd, 32'hDEADBEEF);

    // Single byte lane
    do_req(0, 1'b1, 32'h10, 4'b0100, 32'h00AA0000, rd, er, lat, rdy);
    do_req(0, 1'b0, 32'h10, 4'b0000, 32'h0, rd, er, lat, rdy);
    check_val("lane_ld_data", rd, 32'hDEAABEEF);

    // Null store still responds, writes nothing
    do_req(0, 1'b1, 32'h10, 4'b0000, 32'h12345678, rd, er, lat, rdy);
    check_val("null_lat",     lat, 32'd2);
    check_val("null_rdata",   rd, 32'd0);
    check_val("null_err",     {31'd0, er}, 32'd0);
    do_req(0, 1'b0, 32'h10, 4'b0000, 32'h0, rd, er, lat, rdy);
    check_val("null_ld_data", rd, 32'hDEAABEEF);

    // Load accepted in the store's RESP cycle sees new data
    do_req(0, 1'b1, 32'h14, 4'b1111, 32'h12345678, rd, er, lat, rdy);
    do_req(0, 1'b0, 32'h14, 4'b1111, 32'h0BAD0BAD, rd, er, lat, rdy);
    check_val("raw_ld_data",  rd, 32'h12345678);

    // Out-of-range address (aliases onto word 0 when checking is off)
    do_req(0, 1'b1, 32'h0, 4'b1111, 32'h01020304, rd, er, lat, rdy);
    do_req(0, 1'b1, 32'h1000, 4'b1111, 32'hA5A5A5A5, rd, er, lat, rdy);
    check_val("oob_st_lat",   lat, 32'd2);
`ifdef DMEM_OOB_ERR_EN
    check_val("oob_st_err",   {31'd0, er}, 32'd1);
`else
    check_val("oob_st_err",   {31'd0, er}, 32'd0);
`endif
    check_val("oob_st_rdata", rd, 32'd0);
    do_req(0, 1'b0, 32'h1000, 4'b0000, 32'h0, rd, er, lat, rdy);
`ifdef DMEM_OOB_ERR_EN
    check_val("oob_ld_err",   {31'd0, er}, 32'd1);
    check_val("oob_ld_rdata", rd, 32'd0);
`else
    check_val("oob_ld_err",   {31'd0, er}, 32'd0);
    check_val("oob_ld_rdata", rd, 32'hA5A5A5A5);
`endif
    do_req(0, 1'b0, 32'h0, 4'b0000, 32'h0, rd, er, lat, rdy);
`ifdef DMEM_OOB_ERR_EN
    check_val("oob_word0",    rd, 32'h01020304);
`else
    check_val("oob_word0",    rd, 32'hA5A5A5A5);
`endif

    // WAIT_STATES=0 back-to-back
    check_val("ws0_ready_pre", {31'd0, req_ready[1]}, 32'd1);
    do_req(1, 1'b1, 32'h20, 4'b1111, 32'h11223344, rd, er, lat, rdy);
    check_val("ws0_st_lat",    lat, 32'd1);
    check_val("ws0_st_ready",  {31'd0, rdy}, 32'd1);
    check_val("ws0_ready_rsp", {31'd0, req_ready[1]}, 32'd1);
    do_req(1, 1'b0, 32'h20, 4'b0000, 32'h0, rd, er, lat, rdy);
    check_val("ws0_ld_lat",    lat, 32'd1);
    check_val("ws0_ld_data",   rd, 32'h11223344);
    check_val("ws0_ld_ready",  {31'd0, rdy}, 32'd1);

    // WAIT_STATES=3: reset in WAIT drops the store
    do_req(2, 1'b1, 32'h30, 4'b1111, 32'hCAFEF00D, rd, er, lat, rdy);
    check_val("ws3_st_lat", lat, 32'd4);
    @(posedge clk); #1;
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h30;
    req_byte_en[2] = 4'b1111; req_wdata[2] = 32'h00000055;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    seen = 0;
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid[2]) seen++;
      @(posedge clk); #1;
    end
    check_val("abort_no_rsp", seen, 32'd0);
    do_req(2, 1'b0, 32'h30, 4'b0000, 32'h0, rd, er, lat, rdy);
    check_val("abort_ld_lat",  lat, 32'd4);
    check_val("abort_ld_data", rd, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
